// File: rtl/tt_byron_alu_pkg.sv
// rtl/tt_byron_alu_pkg.sv - command, op and status encodings for the sequential ALU
package tt_byron_alu_pkg;

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_LOAD_A = 3'd1;
    localparam logic [2:0] CMD_LOAD_B = 3'd2;
    localparam logic [2:0] CMD_EXEC   = 3'd3;
    localparam logic [2:0] CMD_RSEL   = 3'd4;
    localparam logic [2:0] CMD_CLR    = 3'd5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;

    localparam int ST_Z    = 0;
    localparam int ST_C    = 1;
    localparam int ST_V    = 2;
    localparam int ST_N    = 3;
    localparam int ST_ERR  = 6;
    localparam int ST_BUSY = 7;

    localparam logic [2:0] RSEL_STATUS = 3'd7;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/byron_mul_seq.sv
// rtl/byron_mul_seq.sv - shift-add multiplier, one partial product per cycle
module byron_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // Partial product 0 is folded into the start edge so the full product
    // is in acc while done is high, letting the caller latch it as busy drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a} << 1;
            mplier <= b >> 1;
            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = acc;

endmodule

// File: rtl/tt_um_byron_alu_seq.sv
// rtl/tt_um_byron_alu_seq.sv - byte-loaded registered ALU top under the Tiny Tapeout harness
module tt_um_byron_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    import tt_byron_alu_pkg::*;

    localparam int NBYTES = WIDTH / 8;
    localparam int SHW    = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic             z_q, c_q, n_q, v_q, err_q;
    logic [2:0]       rsel_q;
    logic             stb_s1, stb_s2, stb_s3;
    state_t           state_q, state_d;

    logic [2:0]         cmd;
    logic [3:0]         op;
    logic               accept, busy, mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] product;
    logic               unused_uio;

    assign cmd        = uio_in[2:0];
    assign op         = ui_in[3:0];
    assign accept     = stb_s2 & ~stb_s3 & ena;
    assign busy       = (state_q == MUL_WAIT) | mul_busy;
    assign unused_uio = &{1'b0, uio_in[7:4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_s1 <= 1'b0;
            stb_s2 <= 1'b0;
            stb_s3 <= 1'b0;
        end else begin
            stb_s1 <= uio_in[3];
            stb_s2 <= stb_s1;
            stb_s3 <= stb_s2;
        end
    end

    byron_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && cmd == CMD_EXEC && op == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (mul_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [WIDTH:0]            sum, diff;
    logic [SHW-1:0]            sh;
    logic [2*WIDTH-1:0]        shl_t, shr_t;
    logic signed [2*WIDTH-1:0] asr_t;
    logic [WIDTH-1:0]          res;
    logic                      res_c, res_v;

    // Shifts run in a double-width window so the last bit shifted out sits
    // at a fixed position next to the result, and is 0 for a zero amount.
    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        diff  = {1'b0, a_q} - {1'b0, b_q};
        sh    = b_q[SHW-1:0];
        shl_t = {{WIDTH{1'b0}}, a_q} << sh;
        shr_t = {a_q, {WIDTH{1'b0}}} >> sh;
        asr_t = $signed({a_q, {WIDTH{1'b0}}}) >>> sh;
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_NOT: res = ~a_q;
            OP_SHL: begin
                res   = shl_t[WIDTH-1:0];
                res_c = shl_t[WIDTH];
            end
            OP_SHR: begin
                res   = shr_t[2*WIDTH-1:WIDTH];
                res_c = shr_t[WIDTH-1];
            end
            OP_ASR: begin
                res   = asr_t[2*WIDTH-1:WIDTH];
                res_c = asr_t[WIDTH-1];
            end
            OP_ROL: begin
                res   = shl_t[WIDTH-1:0] | shl_t[2*WIDTH-1:WIDTH];
                res_c = shl_t[WIDTH];
            end
            default: ;
        endcase
    end

    logic [WIDTH-1:0] r_shift;
    logic [7:0]       rd_byte;

    always_comb begin
        r_shift = r_q >> {rsel_q, 3'b000};
        if (rsel_q == RSEL_STATUS) begin
            rd_byte = {busy, err_q, 2'b00, n_q, v_q, c_q, z_q};
        end else if ({29'd0, rsel_q} < NBYTES) begin
            rd_byte = r_shift[7:0];
        end else begin
            rd_byte = r_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            err_q  <= 1'b0;
            rsel_q <= '0;
            uo_out <= '0;
        end else begin
            if (accept) begin
                if (busy) begin
                    err_q <= 1'b1;
                end else begin
                    case (cmd)
                        CMD_LOAD_A: a_q <= (a_q << 8) | WIDTH'(ui_in);
                        CMD_LOAD_B: b_q <= (b_q << 8) | WIDTH'(ui_in);
                        CMD_EXEC: begin
                            if (op <= OP_ROL || op == OP_CMP) begin
                                if (op != OP_CMP) begin
                                    r_q <= res;
                                end
                                z_q <= (res == '0);
                                n_q <= res[WIDTH-1];
                                c_q <= res_c;
                                v_q <= res_v;
                            end else if (op > OP_CMP) begin
                                err_q <= 1'b1;
                            end
                        end
                        CMD_RSEL: rsel_q <= ui_in[2:0];
                        CMD_CLR: begin
                            a_q   <= '0;
                            b_q   <= '0;
                            r_q   <= '0;
                            z_q   <= 1'b0;
                            c_q   <= 1'b0;
                            n_q   <= 1'b0;
                            v_q   <= 1'b0;
                            err_q <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            if (mul_done) begin
                r_q <= product[WIDTH-1:0];
                z_q <= (product[WIDTH-1:0] == '0);
                n_q <= product[WIDTH-1];
                c_q <= |product[2*WIDTH-1:WIDTH];
                v_q <= 1'b0;
            end
            uo_out <= rd_byte;
        end
    end

    assign uio_out = {busy, err_q, c_q, z_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_byron_alu_seq.sv
// tb/tb_tt_um_byron_alu_seq.sv - randomized self-checking bench against an arithmetic model
module tb_tt_um_byron_alu_seq;
    localparam int W = 16;
    localparam logic [2:0] C_LOAD_A = 3'd1, C_LOAD_B = 3'd2, C_EXEC = 3'd3,
                           C_RSEL = 3'd4, C_CLR = 3'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int checks = 0;
    int errors = 0;

    longint m_a, m_b, m_r;
    bit m_z, m_c, m_n, m_v, m_err;

    always #5 clk = ~clk;

    tt_um_byron_alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clr();
        m_a = 0; m_b = 0; m_r = 0;
        m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_err = 0;
    endtask

    task automatic model_exec(input int op);
        longint mask, half, sa, sb, full, r;
        int s;
        bit c, v;
        mask = (longint'(1) << W) - 1;
        half = longint'(1) << (W - 1);
        sa = (m_a >= half) ? m_a - (longint'(1) << W) : m_a;
        sb = (m_b >= half) ? m_b - (longint'(1) << W) : m_b;
        s = int'(m_b % W);
        c = 0; v = 0; r = 0;
        if (op > 11) begin
            m_err = 1;
        end else begin
            case (op)
                0: begin full = m_a + m_b; r = full & mask; c = full > mask;
                         v = (sa + sb >= half) || (sa + sb < -half); end
                1, 11: begin r = (m_a - m_b) & mask; c = m_a < m_b;
                         v = (sa - sb >= half) || (sa - sb < -half); end
                2: r = m_a & m_b;
                3: r = m_a | m_b;
                4: r = m_a ^ m_b;
                5: r = ~m_a & mask;
                6: begin r = (m_a << s) & mask; c = (s != 0) && (((m_a >> (W - s)) & 1) != 0); end
                7: begin r = m_a >> s; c = (s != 0) && (((m_a >> (s - 1)) & 1) != 0); end
                8: begin r = (sa >>> s) & mask; c = (s != 0) && (((m_a >> (s - 1)) & 1) != 0); end
                9: begin r = ((m_a << s) | (m_a >> (W - s))) & mask;
                         c = (s != 0) && (((m_a >> (W - s)) & 1) != 0); end
                default: begin full = m_a * m_b; r = full & mask; c = (full >> W) != 0; end
            endcase
            m_z = (r == 0);
            m_n = ((r >> (W - 1)) & 1) != 0;
            m_c = c;
            m_v = v;
            if (op != 11) m_r = r;
        end
    endtask

    task automatic send_h(input logic [2:0] cmd, input logic [7:0] d, input int hold);
        uio_in[3] = 1'b0;
        repeat (3) @(negedge clk);
        uio_in[2:0] = cmd;
        ui_in = d;
        uio_in[3] = 1'b1;
        repeat (hold) @(negedge clk);
        uio_in[3] = 1'b0;
    endtask

    task automatic send(input logic [2:0] cmd, input logic [7:0] d);
        send_h(cmd, d, 3);
    endtask

    task automatic read(input logic [2:0] sel, output logic [7:0] v);
        send(C_RSEL, {5'd0, sel});
        @(negedge clk);
        v = uo_out;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (uio_out[7] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", {63'd0, uio_out[7]}, 64'd0);
    endtask

    task automatic load_ab(input longint a, input longint b);
        send(C_LOAD_A, a[15:8]); send(C_LOAD_A, a[7:0]);
        send(C_LOAD_B, b[15:8]); send(C_LOAD_B, b[7:0]);
        m_a = a; m_b = b;
    endtask

    task automatic do_exec(input int op);
        send(C_EXEC, 8'(op));
        model_exec(op);
        wait_idle();
    endtask

    task automatic check_state(input string tag);
        logic [7:0] v;
        read(3'd0, v); chk({tag, "_r0"}, v, m_r & 8'hFF);
        read(3'd1, v); chk({tag, "_r1"}, v, (m_r >> 8) & 8'hFF);
        read(3'd7, v); chk({tag, "_st"}, v, {1'b0, m_err, 2'b00, m_n, m_v, m_c, m_z});
    endtask

    initial begin
        logic [7:0] v;
        int n;
        longint pick[5];
        model_clr();
        repeat (3) @(negedge clk);
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;
        read(3'd7, v); chk("rst_status", v, 8'h00);

        load_ab(16'h1234, 16'h0001); do_exec(0);
        read(3'd0, v); chk("t2_b0", v, 8'h35);
        read(3'd1, v); chk("t2_b1", v, 8'h12);
        read(3'd3, v); chk("t2_rsel3", v, 8'h35);

        load_ab(16'hFFFF, 16'h0001); do_exec(0);
        read(3'd7, v); chk("t3_carry_st", v, 8'h03);
        load_ab(16'h7FFF, 16'h0001); do_exec(0);
        read(3'd7, v); chk("t3_ovf_st", v, 8'h0C);
        check_state("t3");

        load_ab(16'h0003, 16'h0005); do_exec(1);
        read(3'd7, v); chk("t4_sub_st", v, 8'h0A);
        load_ab(16'h0042, 16'h0042); do_exec(11);
        read(3'd7, v); chk("t4_cmp_st", v, 8'h01);
        read(3'd0, v); chk("t4_cmp_keep", v, 8'hFE);

        load_ab(16'h0100, 16'h0101);
        send(C_EXEC, 8'd10);
        model_exec(10);
        n = 0;
        while (uio_out[7] && n < 100) begin n++; @(negedge clk); end
        chk("t5_busy_cycles", n, 16);
        check_state("t5_mul");
        read(3'd7, v); chk("t5_mul_st", v, 8'h02);
        send(C_EXEC, 8'd10);
        model_exec(10);
        send(C_EXEC, 8'd0);
        m_err = 1;
        wait_idle();
        read(3'd7, v); chk("t5_drop_st", v, 8'h42);
        send(C_CLR, 8'h00); model_clr();
        read(3'd7, v); chk("t5_clr_st", v, 8'h00);

        send_h(C_LOAD_A, 8'h11, 12);
        m_a = 16'h0011;
        do_exec(0);
        check_state("held_stb");

        load_ab(16'h0005, 16'h0003);
        ena = 1'b0; send(C_LOAD_A, 8'hAB); ena = 1'b1;
        do_exec(0);
        check_state("ena_off");

        load_ab(16'h1234, 16'h0010);
        send(C_EXEC, 8'd10);
        model_exec(10);
        ena = 1'b0;
        wait_idle();
        ena = 1'b1;
        check_state("ena_mul");

        load_ab(16'h00FF, 16'h0003);
        send(C_EXEC, 8'd10);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_uio", uio_out, 8'h00);
        chk("t6_rst_uo", uo_out, 8'h00);
        model_clr();
        @(negedge clk);
        rst_n = 1'b1;
        do_exec(13);
        check_state("t6");

        pick[0] = 0; pick[1] = 16'hFFFF; pick[2] = 16'h8000; pick[3] = 16'h7FFF;
        for (int i = 0; i < 40; i++) begin
            longint a, b;
            int op;
            pick[4] = $urandom_range(0, 16'hFFFF);
            a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom_range(0, 16'hFFFF);
            b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom_range(0, 16'hFFFF);
            op = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11);
            if ($urandom_range(0, 7) == 0) begin
                send(C_CLR, 8'h00);
                model_clr();
            end
            load_ab(a, b);
            do_exec(op);
            check_state($sformatf("rnd%0d_op%0d", i, op));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
